// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 key event unit.
package ps2_pkg;

  localparam logic [7:0]  PREFIX_EXT   = 8'hE0;
  localparam logic [7:0]  PREFIX_BRK   = 8'hF0;
  localparam logic [7:0]  PREFIX_PAUSE = 8'hE1;
  localparam int unsigned PAUSE_SKIP   = 7;

  // Event word layout: {is_break, is_ext, code[7:0]}
  localparam int unsigned EVT_W       = 10;
  localparam int unsigned EVT_BRK_BIT = 9;
  localparam int unsigned EVT_EXT_BIT = 8;
  localparam int unsigned EVT_CODE_W  = 8;

  // Key-state vectors are indexed by {ext, code}
  localparam int unsigned LUT_IDX_W = 9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } frame_state_t;

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 receive front end: input synchronisers, clock glitch filter and
// frame deframer with parity/stop checking.
// Optional mid-frame watchdog enabled by defining PS2_FRAME_TIMEOUT_EN.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int unsigned DENOISE_LEN    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       c50,
  input  logic       reset_all,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] rx_byte,
  output logic       byte_vld,
  output logic       frame_err
);

  logic [1:0]             clk_sync, dat_sync;
  logic [DENOISE_LEN-1:0] filt_sh;
  logic                   filt_clk, filt_prev, fall, dat_s, timeout;

  frame_state_t state, state_nxt;
  logic [2:0]   bit_cnt, bit_cnt_nxt;
  logic [7:0]   shreg, shreg_nxt;
  logic         par, par_nxt, vld_nxt, err_nxt;

  // Two-flop synchronisers; idle bus level is high on both lines
  always_ff @(posedge c50 or posedge reset_all) begin
    if (reset_all) begin
      clk_sync <= '1;
      dat_sync <= '1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_dat};
    end
  end

  // Glitch filter: output only moves when the whole sample window agrees
  always_ff @(posedge c50 or posedge reset_all) begin
    if (reset_all) begin
      filt_sh   <= '1;
      filt_clk  <= 1'b1;
      filt_prev <= 1'b1;
    end else begin
      filt_sh <= {filt_sh[DENOISE_LEN-2:0], clk_sync[1]};
      if (&filt_sh)
        filt_clk <= 1'b1;
      else if (~|filt_sh)
        filt_clk <= 1'b0;
      filt_prev <= filt_clk;
    end
  end

  assign fall  = filt_prev & ~filt_clk;
  assign dat_s = dat_sync[1];

`ifdef PS2_FRAME_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;

  // Watchdog: cycles since the last falling edge while a frame is open
  always_ff @(posedge c50 or posedge reset_all) begin
    if (reset_all)
      to_cnt <= '0;
    else if (state == ST_IDLE || fall || timeout)
      to_cnt <= '0;
    else
      to_cnt <= to_cnt + 1'b1;
  end

  assign timeout = (state != ST_IDLE) && !fall && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  // Frame state and shift register
  always_ff @(posedge c50 or posedge reset_all) begin
    if (reset_all) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      par       <= 1'b0;
      byte_vld  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shreg     <= shreg_nxt;
      par       <= par_nxt;
      byte_vld  <= vld_nxt;
      frame_err <= err_nxt;
    end
  end

  // Frame sequencing on each filtered falling edge
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    par_nxt     = par;
    vld_nxt     = 1'b0;
    err_nxt     = 1'b0;
    if (fall) begin
      unique case (state)
        ST_IDLE: begin
          if (!dat_s) begin
            state_nxt   = ST_DATA;
            bit_cnt_nxt = '0;
          end
        end
        ST_DATA: begin
          shreg_nxt   = {dat_s, shreg[7:1]};
          bit_cnt_nxt = bit_cnt + 1'b1;
          if (bit_cnt == 3'd7)
            state_nxt = ST_PARITY;
        end
        ST_PARITY: begin
          par_nxt   = dat_s;
          state_nxt = ST_STOP;
        end
        ST_STOP: begin
          state_nxt = ST_IDLE;
          if (dat_s && (^{shreg, par}))
            vld_nxt = 1'b1;
          else
            err_nxt = 1'b1;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
    if (timeout) begin
      state_nxt = ST_IDLE;
      err_nxt   = 1'b1;
    end
  end

  // Shift register is frozen outside DATA, so it still holds the byte when byte_vld fires
  assign rx_byte = shreg;

endmodule

// File: rtl/ps2_key_event_unit.sv
// PS/2 keyboard event unit: prefix decoder, key-state vectors and
// first-word-fall-through event FIFO on top of ps2_rx_frame.
// Optional watchdog (inside ps2_rx_frame) enabled by PS2_FRAME_TIMEOUT_EN.
module ps2_key_event_unit
  import ps2_pkg::*;
#(
  parameter int unsigned DENOISE_LEN    = 16,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                          c50,
  input  logic                          reset_all,
  input  logic                          ps2_clk,
  input  logic                          ps2_dat,
  input  logic                          clr_make,
  input  logic                          clr_break,
  input  logic                          evt_ready,
  output logic                          evt_valid,
  output logic [EVT_W-1:0]              evt_data,
  output logic [(1<<LUT_IDX_W)-1:0]     make_lut,
  output logic [(1<<LUT_IDX_W)-1:0]     persist_lut,
  output logic [(1<<LUT_IDX_W)-1:0]     break_lut,
  output logic                          frame_err,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [7:0] rx_byte;
  logic       byte_vld;

  ps2_rx_frame #(
    .DENOISE_LEN   (DENOISE_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .c50      (c50),
    .reset_all(reset_all),
    .ps2_clk  (ps2_clk),
    .ps2_dat  (ps2_dat),
    .rx_byte  (rx_byte),
    .byte_vld (byte_vld),
    .frame_err(frame_err)
  );

  logic             ext, brk, skip;
  logic             ext_nxt, brk_nxt, skip_nxt;
  logic [2:0]       skip_cnt, skip_cnt_nxt;
  logic             emit;
  logic [EVT_W-1:0] emit_evt;
  logic [LUT_IDX_W-1:0] idx;

  // Prefix decoder; a frame error abandons any partially built sequence
  always_comb begin
    ext_nxt      = ext;
    brk_nxt      = brk;
    skip_nxt     = skip;
    skip_cnt_nxt = skip_cnt;
    emit         = 1'b0;
    emit_evt     = '0;
    if (frame_err) begin
      ext_nxt      = 1'b0;
      brk_nxt      = 1'b0;
      skip_nxt     = 1'b0;
      skip_cnt_nxt = '0;
    end else if (byte_vld) begin
      if (skip) begin
        if (skip_cnt == 3'(PAUSE_SKIP - 1)) begin
          skip_nxt     = 1'b0;
          skip_cnt_nxt = '0;
          emit         = 1'b1;
          emit_evt     = {1'b0, 1'b1, PREFIX_PAUSE};
        end else begin
          skip_cnt_nxt = skip_cnt + 1'b1;
        end
      end else if (rx_byte == PREFIX_EXT) begin
        ext_nxt = 1'b1;
      end else if (rx_byte == PREFIX_BRK) begin
        brk_nxt = 1'b1;
      end else if (rx_byte == PREFIX_PAUSE) begin
        skip_nxt     = 1'b1;
        skip_cnt_nxt = '0;
      end else begin
        emit     = 1'b1;
        emit_evt = {brk, ext, rx_byte};
        ext_nxt  = 1'b0;
        brk_nxt  = 1'b0;
      end
    end
  end

  // Decoder state registers
  always_ff @(posedge c50 or posedge reset_all) begin
    if (reset_all) begin
      ext      <= 1'b0;
      brk      <= 1'b0;
      skip     <= 1'b0;
      skip_cnt <= '0;
    end else begin
      ext      <= ext_nxt;
      brk      <= brk_nxt;
      skip     <= skip_nxt;
      skip_cnt <= skip_cnt_nxt;
    end
  end

  assign idx = emit_evt[LUT_IDX_W-1:0];

  // Key-state vectors; bulk clears first so a same-cycle event wins its bit
  always_ff @(posedge c50 or posedge reset_all) begin
    if (reset_all) begin
      make_lut    <= '0;
      persist_lut <= '0;
      break_lut   <= '0;
    end else begin
      if (clr_make)
        make_lut <= '0;
      if (clr_break)
        break_lut <= '0;
      if (emit) begin
        if (emit_evt[EVT_BRK_BIT]) begin
          persist_lut[idx] <= 1'b0;
          break_lut[idx]   <= 1'b1;
        end else begin
          make_lut[idx]    <= ~persist_lut[idx];
          persist_lut[idx] <= 1'b1;
        end
      end
    end
  end

  logic [EVT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             pop, push;

  assign evt_valid = (fifo_count != '0);
  assign evt_data  = mem[rd_ptr];
  assign pop       = evt_valid & evt_ready;
  assign push      = emit & ((fifo_count != CNT_W'(FIFO_DEPTH)) | pop);

  // Event FIFO; a push into a full FIFO is allowed when a pop frees a slot
  always_ff @(posedge c50 or posedge reset_all) begin
    if (reset_all) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= emit_evt;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (emit && !push)
        overflow <= 1'b1;
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: doc/ps2_key_event_unit.md
Name: ps2_key_event_unit

Overview:
Parametrised PS/2 keyboard receiver that turns raw PS/2 clock and data lines into decoded key events with E0, F0 and E1 prefix handling.
- Checks parity and stop bit on every frame, and drops bad frames.
- Buffers events in a first-word-fall-through FIFO with a valid/ready handshake.
- Maintains the 512-entry make, persist and break key-state vectors read by the game logic.

Parameters:
DENOISE_LEN, 16, length of the PS/2-clock glitch filter in c50 cycles (must be ≥2).
FIFO_DEPTH, 8, depth of the event FIFO (power of 2, ≥2).
TIMEOUT_CYCLES, 100000, mid-frame watchdog limit in c50 cycles (2 ms at 50 MHz).

Ports:
c50  in  1  system clock, 50 MHz.
reset_all  in  1  asynchronous, active-high reset.
ps2_clk  in  1  raw PS/2 clock, asynchronous.
ps2_dat  in  1  raw PS/2 data, asynchronous.
clr_make  in  1  active-high level; clears make_lut while high.
clr_break  in  1  active-high level; clears break_lut while high.
evt_ready  in  1  consumer accepts the head event.
evt_valid  out  1  FIFO is non-empty.
evt_data  out  10  head event, {is_break, is_ext, code[7:0]}.
make_lut  out  512  bit {ext, code} is set on the first make of a key.
persist_lut  out  512  bit {ext, code} is high while the key is held.
break_lut  out  512  bit {ext, code} is set on release.
frame_err  out  1  one-cycle pulse on a parity, stop-bit or timeout error.
overflow  out  1  sticky flag: an event was dropped because the FIFO was full.
fifo_count  out  $clog2(FIFO_DEPTH)+1  number of events held in the FIFO.

Behaviour:
Reset:
- All outputs are 0, FIFO is empty, decoder and prefix state are cleared.
- The filter register resets to all ones and the filtered clock to 1 (idle bus).
- Reset is asynchronous and may land mid-frame; the partial frame is discarded.

Input path and framing:
- ps2_clk and ps2_dat each pass through a 2-flop synchroniser.
- Filtered clock goes to 1 when the last DENOISE_LEN synchronised samples are all 1, and to 0 when they are all 0; otherwise it holds its value.
- A falling edge is filtered_clk = 0 with the previous value = 1. The synchronised data bit is sampled on that edge.
- Frame FSM: IDLE → DATA (8 bits, LSB first) → PARITY → STOP → IDLE.
- IDLE leaves only on a sampled start bit of 0; a 1 keeps it in IDLE.
- A frame is good when data plus parity has odd weight and stop = 1. Otherwise frame_err pulses, the byte is discarded and the prefix flags are cleared.

Decoder (good bytes only):
- E0 sets ext. F0 sets brk.
- E1 enters SKIP, which discards the next 7 good bytes, then emits a make event with ext = 1 and code 0xE1.
- Any other byte emits {brk, ext, byte} and then clears ext and brk.

Key-state update, index = {ext, code}:
- Make: make_lut[index] <= ~persist_lut[index]; persist_lut[index] <= 1. Typematic repeats therefore do not re-set make_lut.
- Break: persist_lut[index] <= 0; break_lut[index] <= 1.
- clr_make and clr_break are applied first; an update in the same cycle wins for its bit.

Latency:
- evt_valid rises exactly 2 c50 cycles after the cycle in which the stop-bit edge is detected.
- The LUT bits update in the same cycle that evt_valid rises.

FIFO:
- Pop happens when evt_valid && evt_ready.
- Push is accepted when count < FIFO_DEPTH, or when a pop occurs in the same cycle.
- A refused push drops the event and sets overflow; the LUTs still update.
- Pointers wrap modulo FIFO_DEPTH.
- evt_data is undefined-but-stable while evt_valid = 0.

Optional Feature:
PS2_FRAME_TIMEOUT_EN
- Defined: a counter runs while the frame FSM is not in IDLE and restarts on every falling edge. When it reaches TIMEOUT_CYCLES, the FSM returns to IDLE, the prefix flags and SKIP state are cleared, and frame_err pulses for one cycle.
- Undefined: there is no watchdog, and a stalled frame waits indefinitely.

Decomposition:
Package ps2_pkg holds:
- PREFIX_EXT = 8'hE0, PREFIX_BRK = 8'hF0, PREFIX_PAUSE = 8'hE1, PAUSE_SKIP = 7.
- Event field positions and EVT_W = 10.
- LUT_IDX_W = 9.
- The frame-state enum.

Sub-module ps2_rx_frame performs synchronisation, filtering and deframing. It outputs byte[7:0], byte_vld and frame_err, and contains the optional watchdog. The top level contains the decoder, the LUTs and the FIFO.

Test Plan:
1. Frames 1C, F0, 1C with evt_ready = 1: events 0x01C then 0x21C. make_lut[0x01C] = 1; persist_lut[0x01C] goes 1 then 0; break_lut[0x01C] = 1.
2. Frames E0 75, E0 75, E0 F0 75: events 0x175, 0x175, 0x375. Pulse clr_make between the two makes: make_lut[0x175] stays 0 after the second make.
3. Frame 1C with a wrong parity bit: frame_err pulses once, no event, no LUT change. A following good frame 1C yields 0x01C.
4. evt_ready = 0 with 9 distinct makes (FIFO_DEPTH = 8): fifo_count = 8 and overflow = 1. persist_lut holds all 9 keys. Draining returns the first 8 in order.
5. Glitches on ps2_clk of DENOISE_LEN−1 cycles between frames: no edge detected. Sequence E1 14 77 E1 F0 14 F0 77: a single event 0x1E1.
6. With the macro defined, stop after 4 data bits and hold ps2_clk high for TIMEOUT_CYCLES: frame_err pulses and the FSM returns to IDLE. Assert reset_all mid-frame: all outputs become 0 immediately.
